// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: two-byte instruction fetch stage feeding the control decoder.
//
// Owns the program counter. On fetch_start it reads the opcode byte (ir1) and then
// the operand byte (ir2) from instruction memory over a req/ack handshake, then
// pulses instr_valid for one cycle. Branch redirects (pc_load) are honoured only
// between fetches. Fetching an opcode nibble of 4'hB latches a sticky halt.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   defined   - a wait counter aborts a request that sees no mem_ack within
//               TIMEOUT_CYCLES cycles and sets the sticky fault flag.
//   undefined - the unit waits forever for mem_ack; fault is tied low.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   fetch_start           request the next instruction (only acted on in IDLE)
//   pc_load, pc_target    branch redirect (only acted on in IDLE and DONE)
//   mem_req, mem_addr     memory read request and address (mem_addr == pc)
//   mem_rdata, mem_ack    memory read data and one-cycle completion pulse
//   ir1, ir2, opcode      instruction bytes and ir1[7:4]
//   pc                    current program counter
//   instr_valid           one-cycle pulse: ir1/ir2 hold a new instruction
//   busy                  high in FETCH1/FETCH2/DONE
//   halted, fault         sticky halt and timeout flags
`timescale 1ns/1ps

module instr_fetch_unit #(
  parameter int unsigned       ADDR_W         = 8,
  parameter int unsigned       DATA_W         = 8,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter int unsigned       TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_start,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] ir1,
  output logic [DATA_W-1:0] ir2,
  output logic [3:0]        opcode,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  typedef enum logic [1:0] {StIdle, StFetch1, StFetch2, StDone} state_e;

  localparam logic [3:0] HALT_OP = 4'b1011;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir1_q;
  logic [DATA_W-1:0] ir2_q;
  logic              mem_req_q;
  logic              instr_valid_q;
  logic              halted_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned       CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q;
  logic             fault_q;
  logic             timeout_hit;

  // Fires on the cycle whose count would reach TIMEOUT_CYCLES, so mem_req is
  // high for exactly TIMEOUT_CYCLES cycles before it drops.
  assign timeout_hit = mem_req_q && !mem_ack && (wait_cnt_q == CNT_LAST);
  assign fault       = fault_q;
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      ir1_q         <= '0;
      ir2_q         <= '0;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt_q    <= '0;
      fault_q       <= 1'b0;
`endif
    end else begin
      instr_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Redirect and start may coincide; FETCH1 then reads from pc_target.
          if (pc_load) pc_q <= pc_target;
          if (fetch_start && !halted_q && !fault) begin
            state_q   <= StFetch1;
            mem_req_q <= 1'b1;
          end
        end
        StFetch1: begin
          if (mem_ack) begin
            ir1_q   <= mem_rdata;
            pc_q    <= pc_q + ADDR_W'(1);
            state_q <= StFetch2;
            if (mem_rdata[7:4] == HALT_OP) halted_q <= 1'b1;
          end
        end
        StFetch2: begin
          if (mem_ack) begin
            ir2_q         <= mem_rdata;
            pc_q          <= pc_q + ADDR_W'(1);
            state_q       <= StDone;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (pc_load) pc_q <= pc_target;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

`ifdef FETCH_TIMEOUT_EN
      if (state_q == StIdle) begin
        wait_cnt_q <= '0;
      end else if (mem_req_q) begin
        wait_cnt_q <= mem_ack ? '0 : wait_cnt_q + 1'b1;
      end
      // Abort overrides whatever the case statement scheduled this cycle.
      if (timeout_hit) begin
        state_q   <= StIdle;
        mem_req_q <= 1'b0;
        fault_q   <= 1'b1;
      end
`endif
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign ir1         = ir1_q;
  assign ir2         = ir2_q;
  assign opcode      = ir1_q[7:4];
  assign instr_valid = instr_valid_q;
  assign busy        = (state_q != StIdle);
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit. A memory responder serves requests with
// per-request wait counts chosen by the stimulus; expected instructions, addresses
// and arrival cycles come from a byte-array model of memory and a model PC.
`timescale 1ns/1ps

module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fetch_start = 1'b0;
  logic       pc_load = 1'b0;
  logic [7:0] pc_target = 8'h00;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ack = 1'b0;
  logic [7:0] ir1;
  logic [7:0] ir2;
  logic [3:0] opcode;
  logic [7:0] pc;
  logic       instr_valid;
  logic       busy;
  logic       halted;
  logic       fault;

  instr_fetch_unit #(
    .ADDR_W(8),
    .DATA_W(8),
    .RESET_PC(8'h00),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fetch_start(fetch_start),
    .pc_load(pc_load),
    .pc_target(pc_target),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .ir1(ir1),
    .ir2(ir2),
    .opcode(opcode),
    .pc(pc),
    .instr_valid(instr_valid),
    .busy(busy),
    .halted(halted),
    .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic [7:0] ir1;
    logic [7:0] ir2;
    logic [7:0] pc;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] addr_q[$];
  int         wait_q[$];
  logic [7:0] mem[256];
  int         cyc = 0;

  logic [7:0] model_pc = 8'h00;
  logic [7:0] last_ir1 = 8'h00;
  logic [7:0] last_ir2 = 8'h00;
  bit         spur = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reset abandons any outstanding request: drop its remaining expectations.
  always @(posedge clk) begin
    if (reset) begin
      addr_q.delete();
      wait_q.delete();
    end
  end

  // Memory responder: checks request address and its stability, acks after the
  // chosen wait, and can inject an ack while no request is pending.
  bit         req_open = 1'b0;
  int         wcnt = 0;
  int         cur_wait = 0;
  logic [7:0] held_addr = 8'h00;

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req) begin
      if (!req_open) begin
        req_open  = 1'b1;
        wcnt      = 0;
        held_addr = mem_addr;
        if (addr_q.size() == 0) begin
          chk("unexpected_req", {31'd0, mem_req}, 32'd0);
          cur_wait = 0;
        end else begin
          chk("req_addr", {24'd0, mem_addr}, {24'd0, addr_q.pop_front()});
          cur_wait = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
        end
      end else begin
        chk("addr_stable", {24'd0, mem_addr}, {24'd0, held_addr});
      end
      if (wcnt >= cur_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        req_open  = 1'b0;
      end else begin
        wcnt++;
      end
    end else begin
      req_open = 1'b0;
      if (spur) begin
        mem_ack   = 1'b1;
        mem_rdata = 8'($urandom);
      end
    end
  end

  // Monitor: every instr_valid pulse is matched against the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (instr_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {31'd0, instr_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("ir1", {24'd0, ir1}, {24'd0, e.ir1});
        chk("ir2", {24'd0, ir2}, {24'd0, e.ir2});
        chk("opcode", {28'd0, opcode}, {28'd0, e.ir1[7:4]});
        chk("pc_at_done", {24'd0, pc}, {24'd0, e.pc});
        chk("valid_cycle", cyc, e.cyc);
      end
    end
  end

  // One instruction fetch. mode: 0 plain, 1 pc_load mid-fetch (ignored),
  // 2 pc_load in DONE (honoured), 3 extra fetch_start mid-fetch (ignored).
  task automatic issue(input bit ld, input logic [7:0] tgt, input int w1, input int w2,
                       input int mode, input logic [7:0] mtgt);
    logic [7:0] start;
    int         total;
    int         kk;
    exp_t       e;
    @(negedge clk);
    start       = ld ? tgt : model_pc;
    fetch_start = 1'b1;
    pc_load     = ld;
    pc_target   = tgt;
    wait_q.push_back(w1);
    wait_q.push_back(w2);
    addr_q.push_back(start);
    addr_q.push_back(start + 8'd1);
    total = 2 + w1 + w2;
    e.ir1 = mem[start];
    e.ir2 = mem[8'(start + 8'd1)];
    e.pc  = start + 8'd2;
    e.cyc = cyc + total + 1;
    exp_q.push_back(e);
    kk = $urandom_range(1, total);
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      fetch_start = 1'b0;
      pc_load     = 1'b0;
      if (k == kk && mode == 1) begin
        pc_load   = 1'b1;
        pc_target = mtgt;
      end
      if (k == kk && mode == 3) fetch_start = 1'b1;
      if (k == total + 1 && mode == 2) begin
        pc_load   = 1'b1;
        pc_target = mtgt;
      end
    end
    @(negedge clk);
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    last_ir1    = e.ir1;
    last_ir2    = e.ir2;
    model_pc    = (mode == 2) ? mtgt : e.pc;
  endtask

  task automatic spurious_ack();
    @(posedge clk);
    #1 spur = 1'b1;
    @(posedge clk);
    #1 spur = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    model_pc = 8'h00;
    last_ir1 = 8'h00;
    last_ir2 = 8'h00;
  endtask

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      if (b[7:4] == 4'hB) b[7] = 1'b0;
      mem[i] = b;
    end
    mem[0] = 8'h45;
    mem[1] = 8'h12;

    repeat (2) @(negedge clk);
    chk("rst_ir1", {24'd0, ir1}, 32'd0);
    chk("rst_ir2", {24'd0, ir2}, 32'd0);
    chk("rst_opcode", {28'd0, opcode}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    reset = 1'b0;

    issue(1'b0, 8'h00, 0, 0, 0, 8'h00);   // 45/12 zero wait, valid 3 cycles later
    issue(1'b0, 8'h00, 3, 3, 0, 8'h00);   // 3-cycle ack delays, valid 9 cycles later
    issue(1'b1, 8'hFF, 0, 0, 0, 8'h00);   // addresses FF then 00, pc wraps to 01
    issue(1'b0, 8'h00, 1, 2, 1, 8'h80);   // mid-fetch redirect ignored

    spurious_ack();
    chk("spur_ir1", {24'd0, ir1}, {24'd0, last_ir1});
    chk("spur_ir2", {24'd0, ir2}, {24'd0, last_ir2});
    chk("spur_busy", {31'd0, busy}, 32'd0);
    chk("spur_pc", {24'd0, pc}, {24'd0, model_pc});

    for (int n = 0; n < 40; n++) begin
      issue(($urandom % 4) == 0, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), 8'($urandom));
    end
    chk("idle_pc", {24'd0, pc}, {24'd0, model_pc});

    // Reset during FETCH1; a late ack afterwards must not be captured.
    @(negedge clk);
    fetch_start = 1'b1;
    addr_q.push_back(model_pc);
    wait_q.push_back(5);
    wait_q.push_back(5);
    @(negedge clk);
    fetch_start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    model_pc = 8'h00;
    last_ir1 = 8'h00;
    last_ir2 = 8'h00;
    chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_pc", {24'd0, pc}, 32'd0);
    spurious_ack();
    chk("late_ack_ir1", {24'd0, ir1}, 32'd0);
    chk("late_ack_ir2", {24'd0, ir2}, 32'd0);
    chk("late_ack_busy", {31'd0, busy}, 32'd0);

    // HALT opcode: instruction still completes, later starts are ignored.
    mem[model_pc] = 8'hB0;
    issue(1'b0, 8'h00, 1, 0, 0, 8'h00);
    chk("halted", {31'd0, halted}, 32'd1);
    @(negedge clk);
    fetch_start = 1'b1;
    @(negedge clk);
    fetch_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("halt_no_req", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
    end
    do_reset();
    chk("halt_cleared", {31'd0, halted}, 32'd0);

`ifdef FETCH_TIMEOUT_EN
    begin
      int hi;
      hi = 0;
      @(negedge clk);
      fetch_start = 1'b1;
      addr_q.push_back(model_pc);
      wait_q.push_back(1000);
      @(negedge clk);
      fetch_start = 1'b0;
      for (int k = 0; k < 40; k++) begin
        if (mem_req) hi++;
        @(negedge clk);
      end
      chk("timeout_req_cycles", hi, 15);
      chk("timeout_fault", {31'd0, fault}, 32'd1);
      chk("timeout_busy", {31'd0, busy}, 32'd0);
      fetch_start = 1'b1;
      @(negedge clk);
      fetch_start = 1'b0;
      for (int k = 0; k < 4; k++) begin
        chk("fault_no_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
      end
      do_reset();
      chk("fault_cleared", {31'd0, fault}, 32'd0);
    end
`else
    chk("fault_tied_low", {31'd0, fault}, 32'd0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    chk("addr_drained", addr_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
